// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: valid/ready pipeline register (PC + instruction) with a 2-entry skid buffer, flush and NOP bubbles.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt / bubble_cnt performance counters.
module pipe_stage_regs #(
    parameter int                PC_W     = 64,
    parameter int                INST_W   = 32,
    parameter logic [PC_W-1:0]   PC_RST   = 64'h8000_0000,
    parameter logic [INST_W-1:0] INST_RST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     main_pc;
    logic [INST_W-1:0]   main_inst;
    logic [PC_W-1:0]     skid_pc;
    logic [INST_W-1:0]   skid_inst;
    logic                in_fire;
    logic                out_fire;

    // Handshake flags decode only the state register, so out_ready never reaches in_ready.
    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign out_pc    = main_pc;
    assign out_inst  = main_inst;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_pc   <= PC_RST;
            main_inst <= INST_RST;
            skid_pc   <= PC_RST;
            skid_inst <= INST_RST;
        end else if (flush) begin
            state     <= ST_EMPTY;
            main_pc   <= PC_RST;
            main_inst <= INST_RST;
            skid_pc   <= PC_RST;
            skid_inst <= INST_RST;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state     <= ST_FULL;
                        main_pc   <= in_pc;
                        main_inst <= in_inst;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_pc   <= in_pc;
                        main_inst <= in_inst;
                    end else if (in_fire) begin
                        // Downstream stalled: park the newer entry behind the one on the outputs.
                        state     <= ST_SKID;
                        skid_pc   <= in_pc;
                        skid_inst <= in_inst;
                    end else if (out_fire) begin
                        state     <= ST_EMPTY;
                        main_pc   <= PC_RST;
                        main_inst <= INST_RST;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state     <= ST_FULL;
                        main_pc   <= skid_pc;
                        main_inst <= skid_inst;
                        skid_pc   <= PC_RST;
                        skid_inst <= INST_RST;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    main_pc   <= PC_RST;
                    main_inst <= INST_RST;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && (bubble_cnt != 32'hFFFF_FFFF))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: directed and randomized checks of pipe_stage_regs against a 2-deep FIFO model.
// Perf counter checks are included when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_regs;

    localparam logic [63:0] PC_RST   = 64'h8000_0000;
    localparam logic [31:0] INST_RST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } item_t;

    // Reference: the stage is a 2-entry FIFO whose head is shown on the outputs.
    item_t       q[$];
    logic [31:0] m_stall;
    logic [31:0] m_bubble;

    pipe_stage_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    wire [97:0] observed = {out_valid, in_ready, out_pc, out_inst};

    function automatic logic [97:0] model_out();
        logic rdy;
        rdy = (q.size() < 2);
        if (q.size() == 0)
            return {1'b0, 1'b1, PC_RST, INST_RST};
        return {1'b1, rdy, q[0].pc, q[0].inst};
    endfunction

    task automatic model_clear();
        q.delete();
        m_stall  = 32'd0;
        m_bubble = 32'd0;
    endtask

    // Drive one cycle of inputs, advance the reference model across the edge, return #1 after it.
    task automatic cycle(input logic v, input logic r, input logic f,
                         input logic [63:0] pc, input logic [31:0] inst);
        logic exp_valid;
        logic do_push;
        logic do_pop;
        item_t it;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_pc     = pc;
        in_inst   = inst;
        exp_valid = (q.size() > 0);
        do_push   = v && (q.size() < 2);
        do_pop    = exp_valid && r;
        it.pc     = pc;
        it.inst   = inst;
        @(posedge clk);
        if (exp_valid && !r && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (!exp_valid && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'd1;
        if (f) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(it);
        end
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [97:0] exp_v;
        exp_v = {1'b0, 1'b1, PC_RST, INST_RST};
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 64'h1234, 32'hABCD);
        cycle(1'b1, 1'b0, 1'b0, 64'h5678, 32'hBEEF);
        // Mid-cycle async reset must clear outputs without waiting for a clock edge.
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (observed !== exp_v) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h expected %h", observed, exp_v);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (observed !== exp_v) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected %h", observed, exp_v);
        end
        cycle(1'b0, 1'b1, 1'b0, 64'hDEAD, 32'hDEAD);
        checks++;
        if (observed !== exp_v) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h expected %h", observed, exp_v);
        end
    endtask

    task automatic test_streaming();
        logic [97:0] exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
            exp_v = {1'b1, 1'b1, 64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i)};
            checks++;
            if (observed !== exp_v || observed !== model_out()) begin
                errors++;
                $display("[TB] FAIL stream_%0d: got %h expected %h", i, observed, exp_v);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
        checks++;
        if (observed !== model_out()) begin
            errors++;
            $display("[TB] FAIL stream_drain: got %h expected %h", observed, model_out());
        end
    endtask

    task automatic test_backpressure();
        logic [97:0] exp_a_skid;
        logic [97:0] exp_a_full;
        logic [97:0] exp_b;
        exp_a_skid = {1'b1, 1'b0, 64'hA000, 32'hAAAA};
        exp_a_full = {1'b1, 1'b1, 64'hA000, 32'hAAAA};
        exp_b      = {1'b1, 1'b1, 64'hB000, 32'hBBBB};
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 64'hA000, 32'hAAAA);
        checks++;
        if (observed !== exp_a_full) begin
            errors++;
            $display("[TB] FAIL bp_full_a: got %h expected %h", observed, exp_a_full);
        end
        cycle(1'b1, 1'b0, 1'b0, 64'hB000, 32'hBBBB);
        checks++;
        if (observed !== exp_a_skid) begin
            errors++;
            $display("[TB] FAIL bp_skid: got %h expected %h", observed, exp_a_skid);
        end
        // in_ready is low, so C must be refused while the stall persists.
        cycle(1'b1, 1'b0, 1'b0, 64'hC000, 32'hCCCC);
        checks++;
        if (observed !== exp_a_skid) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %h expected %h", observed, exp_a_skid);
        end
        cycle(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
        checks++;
        if (observed !== exp_b) begin
            errors++;
            $display("[TB] FAIL bp_b_after_a: got %h expected %h", observed, exp_b);
        end
        cycle(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
        checks++;
        if (observed !== model_out()) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %h expected %h", observed, model_out());
        end
    endtask

    task automatic test_flush_skid();
        logic [97:0] exp_v;
        exp_v = {1'b0, 1'b1, PC_RST, INST_RST};
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 64'hA100, 32'hA1A1);
        cycle(1'b1, 1'b0, 1'b0, 64'hB100, 32'hB1B1);
        cycle(1'b1, 1'b1, 1'b1, 64'hC100, 32'hC1C1);
        checks++;
        if (observed !== exp_v) begin
            errors++;
            $display("[TB] FAIL flush_skid: got %h expected %h", observed, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'hB100, 32'hB1B1);
            checks++;
            if (observed !== exp_v) begin
                errors++;
                $display("[TB] FAIL flush_no_leak_%0d: got %h expected %h", i, observed, exp_v);
            end
        end
    endtask

    task automatic test_drain();
        logic [97:0] exp_v;
        exp_v = {1'b0, 1'b1, PC_RST, INST_RST};
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 64'hD000, 32'hD0D0);
        cycle(1'b0, 1'b1, 1'b0, 64'hFFFF, 32'hFFFF);
        checks++;
        if (observed !== exp_v) begin
            errors++;
            $display("[TB] FAIL drain: got %h expected %h", observed, exp_v);
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 64'hE000, 32'hE0E0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        checks++;
        if (stall_cnt !== m_stall || stall_cnt !== 32'd5) begin
            errors++;
            $display("[TB] FAIL perf_stall: got %0d expected %0d", stall_cnt, m_stall);
        end
        cycle(1'b0, 1'b1, 1'b1, 64'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
            checks++;
            if (stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
                errors++;
                $display("[TB] FAIL perf_after_flush_%0d: got stall=%0d bubble=%0d expected stall=%0d bubble=%0d",
                         i, stall_cnt, bubble_cnt, m_stall, m_bubble);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic        v;
        logic        r;
        logic        f;
        logic [63:0] pc;
        logic [31:0] inst;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 2) != 0);
            f    = ($urandom_range(0, 24) == 0);
            pc   = {$urandom, $urandom};
            inst = $urandom;
            cycle(v, r, f, pc, inst);
            checks++;
            if (observed !== model_out()) begin
                errors++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, observed, model_out());
            end
`ifdef PIPE_STAGE_PERF_EN
            checks++;
            if (stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
                errors++;
                $display("[TB] FAIL random_perf_%0d: got stall=%0d bubble=%0d expected stall=%0d bubble=%0d",
                         i, stall_cnt, bubble_cnt, m_stall, m_bubble);
            end
`endif
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        m_stall   = 32'd0;
        m_bubble  = 32'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_skid();
        test_drain();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
